// File: rtl/writeback_unit.sv
// Writeback stage of the 16-bit MIPS core: retires ALU results and loads into the
// register file, performing the variable-latency data-memory read with a timeout.
module writeback_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_reg_write,
    input  logic        in_is_load,
    input  logic        in_load_byte,
    input  logic [2:0]  in_dest,
    input  logic [15:0] in_alu_result,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        write_EN,
    output logic [2:0]  reg_write_add,
    output logic [15:0] reg_write_data,
    output logic        pending_valid,
    output logic [2:0]  pending_add,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        WRITE
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        eff_write;
    logic        timeout_hit;
    logic [7:0]  wait_count;
    logic [2:0]  dest_q;
    logic        byte_q;
    logic [7:0]  sel_byte;
    logic [15:0] load_data;

    assign accept      = in_valid & in_ready;
    assign eff_write   = in_reg_write & (in_dest != 3'd0);
    assign timeout_hit = (wait_count == TIMEOUT_LAST);

    // Byte lane picked by the held address; a late response still sees the load's address.
    assign sel_byte  = mem_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign load_data = byte_q ? {{8{sel_byte[7]}}, sel_byte} : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, WRITE: begin
                if (accept && eff_write) begin
                    next_state = in_is_load ? MEM_WAIT : WRITE;
                end else begin
                    next_state = IDLE;
                end
            end
            MEM_WAIT: begin
                // Data arriving on the final allowed edge beats the timeout.
                if (mem_rvalid) begin
                    next_state = WRITE;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state != MEM_WAIT);
        write_EN      = (state == WRITE);
        pending_valid = (state != IDLE);
        reg_write_add = dest_q;
        pending_add   = dest_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req        <= 1'b0;
            mem_addr       <= 16'd0;
            dest_q         <= 3'd0;
            byte_q         <= 1'b0;
            reg_write_data <= 16'd0;
            wait_count     <= 8'd0;
            mem_err        <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            if (accept && eff_write) begin
                dest_q <= in_dest;
                if (in_is_load) begin
                    mem_req    <= 1'b1;
                    mem_addr   <= in_alu_result;
                    byte_q     <= in_load_byte;
                    wait_count <= 8'd0;
                end else begin
                    reg_write_data <= in_alu_result;
                end
            end
            if (state == MEM_WAIT) begin
                if (mem_rvalid) begin
                    reg_write_data <= load_data;
                end else begin
                    wait_count <= wait_count + 8'd1;
                    if (timeout_hit) begin
                        mem_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model of the stage.
module tb_writeback_unit;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_reg_write = 1'b0;
    logic        in_is_load = 1'b0;
    logic        in_load_byte = 1'b0;
    logic [2:0]  in_dest = 3'd0;
    logic [15:0] in_alu_result = 16'd0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_rvalid = 1'b0;
    logic        write_EN;
    logic [2:0]  reg_write_add;
    logic [15:0] reg_write_data;
    logic        pending_valid;
    logic [2:0]  pending_add;
    logic        mem_err;

    int n_compared = 0;
    int n_mismatched = 0;
    bit checking = 1'b0;

    writeback_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_reg_write(in_reg_write),
        .in_is_load(in_is_load),
        .in_load_byte(in_load_byte),
        .in_dest(in_dest),
        .in_alu_result(in_alu_result),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid),
        .write_EN(write_EN),
        .reg_write_add(reg_write_add),
        .reg_write_data(reg_write_data),
        .pending_valid(pending_valid),
        .pending_add(pending_add),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding transaction, either waiting on memory or due to write.
    bit          m_loading;
    bit          m_write_due;
    bit          m_req;
    bit          m_err;
    bit          m_byte;
    logic [2:0]  m_dest;
    logic [15:0] m_data;
    logic [15:0] m_addr;
    int          m_waited;

    function automatic logic [15:0] expect_load(input logic [15:0] addr, input bit is_byte,
                                                input logic [15:0] rdata);
        int b;
        if (!is_byte) return rdata;
        if (int'(addr) % 2 == 1) b = int'(rdata) / 256;
        else b = int'(rdata) % 256;
        if (b >= 128) b = b - 256;
        return 16'(b);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading   <= 1'b0;
            m_write_due <= 1'b0;
            m_req       <= 1'b0;
            m_err       <= 1'b0;
            m_byte      <= 1'b0;
            m_dest      <= 3'd0;
            m_data      <= 16'd0;
            m_addr      <= 16'd0;
            m_waited    <= 0;
        end else if (m_loading) begin
            m_req <= 1'b0;
            if (mem_rvalid) begin
                m_loading   <= 1'b0;
                m_write_due <= 1'b1;
                m_data      <= expect_load(m_addr, m_byte, mem_rdata);
            end else begin
                m_waited <= m_waited + 1;
                if (m_waited + 1 == TIMEOUT) begin
                    m_loading <= 1'b0;
                    m_err     <= 1'b1;
                end
            end
        end else begin
            m_write_due <= 1'b0;
            m_req       <= 1'b0;
            if (in_valid && in_reg_write && in_dest != 3'd0) begin
                m_dest <= in_dest;
                if (in_is_load) begin
                    m_loading <= 1'b1;
                    m_req     <= 1'b1;
                    m_addr    <= in_alu_result;
                    m_byte    <= in_load_byte;
                    m_waited  <= 0;
                end else begin
                    m_write_due <= 1'b1;
                    m_data      <= in_alu_result;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("in_ready", 16'(in_ready), 16'(!m_loading));
            checkOutput("write_EN", 16'(write_EN), 16'(m_write_due));
            checkOutput("pending_valid", 16'(pending_valid), 16'(m_loading || m_write_due));
            checkOutput("mem_req", 16'(mem_req), 16'(m_req));
            checkOutput("mem_err", 16'(mem_err), 16'(m_err));
            if (m_write_due) begin
                checkOutput("reg_write_add", 16'(reg_write_add), 16'(m_dest));
                checkOutput("reg_write_data", reg_write_data, m_data);
            end
            if (m_loading || m_write_due) begin
                checkOutput("pending_add", 16'(pending_add), 16'(m_dest));
            end
            if (m_loading) begin
                checkOutput("mem_addr", mem_addr, m_addr);
            end
        end
    end

    task automatic applyStimulus(input bit valid, input bit reg_write, input bit is_load,
                                 input bit load_byte, input logic [2:0] dest,
                                 input logic [15:0] alu, input bit rvalid,
                                 input logic [15:0] rdata);
        #1;
        in_valid      = valid;
        in_reg_write  = reg_write;
        in_is_load    = is_load;
        in_load_byte  = load_byte;
        in_dest       = dest;
        in_alu_result = alu;
        mem_rvalid    = rvalid;
        mem_rdata     = rdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 16'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " in_ready"}, 16'(in_ready), 16'd1);
        checkOutput({tag, " mem_req"}, 16'(mem_req), 16'd0);
        checkOutput({tag, " mem_addr"}, mem_addr, 16'd0);
        checkOutput({tag, " write_EN"}, 16'(write_EN), 16'd0);
        checkOutput({tag, " reg_write_add"}, 16'(reg_write_add), 16'd0);
        checkOutput({tag, " reg_write_data"}, reg_write_data, 16'd0);
        checkOutput({tag, " pending_valid"}, 16'(pending_valid), 16'd0);
        checkOutput({tag, " pending_add"}, 16'(pending_add), 16'd0);
        checkOutput({tag, " mem_err"}, 16'(mem_err), 16'd0);
    endtask

    // Single-cycle-response load (rvalid on the first edge after accept) and its written value.
    task automatic byteLoad(input logic [15:0] addr, input logic [15:0] rdata,
                            input logic [15:0] expected);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd6, addr, 1'b0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, rdata);
        checkOutput("byte write_EN", 16'(write_EN), 16'd1);
        checkOutput("byte data", reg_write_data, expected);
        idleCycle();
    endtask

    initial begin
        #1 rst = 1'b1;
        checking = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkResetValues("reset");
        #1 rst = 1'b0;
        @(negedge clk);

        // Single ALU op.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h1234, 1'b0, 16'd0);
        checkOutput("alu write_EN", 16'(write_EN), 16'd1);
        checkOutput("alu add", 16'(reg_write_add), 16'd3);
        checkOutput("alu data", reg_write_data, 16'h1234);
        checkOutput("alu in_ready", 16'(in_ready), 16'd1);
        idleCycle();
        checkOutput("alu write once", 16'(write_EN), 16'd0);

        // Back-to-back ALU ops, then suppressed writes.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'hAAAA, 1'b0, 16'd0);
        checkOutput("b2b1 data", reg_write_data, 16'hAAAA);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h5555, 1'b0, 16'd0);
        checkOutput("b2b2 add", 16'(reg_write_add), 16'd2);
        checkOutput("b2b2 data", reg_write_data, 16'h5555);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h00FF, 1'b0, 16'd0);
        checkOutput("b2b3 write_EN", 16'(write_EN), 16'd1);
        checkOutput("b2b3 data", reg_write_data, 16'h00FF);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h1111, 1'b0, 16'd0);
        checkOutput("r0 write_EN", 16'(write_EN), 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 16'h2222, 1'b0, 16'd0);
        checkOutput("nowrite write_EN", 16'(write_EN), 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0040, 1'b0, 16'd0);
        checkOutput("r0 load mem_req", 16'(mem_req), 16'd0);
        checkOutput("r0 load in_ready", 16'(in_ready), 16'd1);

        // Word load, response on the third edge.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'h0040, 1'b0, 16'd0);
        checkOutput("wload mem_req", 16'(mem_req), 16'd1);
        checkOutput("wload mem_addr", mem_addr, 16'h0040);
        checkOutput("wload in_ready", 16'(in_ready), 16'd0);
        checkOutput("wload pending_add", 16'(pending_add), 16'd4);
        idleCycle();
        checkOutput("wload req pulse", 16'(mem_req), 16'd0);
        checkOutput("wload addr held", mem_addr, 16'h0040);
        idleCycle();
        checkOutput("wload still busy", 16'(in_ready), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 16'hBEEF);
        checkOutput("wload write_EN", 16'(write_EN), 16'd1);
        checkOutput("wload add", 16'(reg_write_add), 16'd4);
        checkOutput("wload data", reg_write_data, 16'hBEEF);
        idleCycle();

        // Byte loads with sign extension.
        byteLoad(16'h0041, 16'h80FF, 16'hFF80);
        byteLoad(16'h0040, 16'h80FF, 16'hFFFF);
        byteLoad(16'h0040, 16'h127F, 16'h007F);

        // Response on the last allowed edge wins over the timeout.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 16'h0100, 1'b0, 16'd0);
        for (int i = 0; i < TIMEOUT - 1; i++) idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 16'hCAFE);
        checkOutput("edge4 write_EN", 16'(write_EN), 16'd1);
        checkOutput("edge4 data", reg_write_data, 16'hCAFE);
        checkOutput("edge4 mem_err", 16'(mem_err), 16'd0);
        idleCycle();

        // Timeout with a later stray response.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'h0200, 1'b0, 16'd0);
        for (int i = 0; i < TIMEOUT - 1; i++) idleCycle();
        checkOutput("tmo before in_ready", 16'(in_ready), 16'd0);
        idleCycle();
        checkOutput("tmo in_ready", 16'(in_ready), 16'd1);
        checkOutput("tmo mem_err", 16'(mem_err), 16'd1);
        checkOutput("tmo write_EN", 16'(write_EN), 16'd0);
        checkOutput("tmo pending_valid", 16'(pending_valid), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 16'h1357);
        checkOutput("stray write_EN", 16'(write_EN), 16'd0);
        checkOutput("stray mem_err", 16'(mem_err), 16'd1);

        // Reset in the middle of a load, then a late response.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0300, 1'b0, 16'd0);
        idleCycle();
        #1 rst = 1'b1;
        #1 checkResetValues("midreset");
        @(negedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 16'h2468);
        checkOutput("postreset write_EN", 16'(write_EN), 16'd0);
        checkOutput("postreset in_ready", 16'(in_ready), 16'd1);
        checkOutput("postreset pending", 16'(pending_valid), 16'd0);

        // Randomized traffic checked by the per-cycle compare process.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), 16'($urandom),
                          $urandom_range(0, 9) < 3, 16'($urandom));
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of the 16-bit MIPS core: accepts retiring instructions from the execute stage over a valid/ready handshake, performs the data-memory read for loads (variable latency, with timeout), formats load data, and drives the register file write port. It also exports the pending destination register so decode-side hazard logic can stall or forward.

## Interface
- MEM_TIMEOUT, 15: maximum clock edges to wait for `mem_rvalid` after a load is accepted; legal range 1..255.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  execute stage presents an instruction
- in_ready  output  1  unit can accept this cycle
- in_reg_write  input  1  instruction writes a register
- in_is_load  input  1  instruction is a load; `in_alu_result` is the address
- in_load_byte  input  1  byte load (sign-extended); ignored unless `in_is_load`
- in_dest  input  3  destination register address
- in_alu_result  input  16  ALU result or load address
- mem_req  output  1  one-cycle read-request pulse
- mem_addr  output  16  read address, held stable until the response or timeout
- mem_rdata  input  16  read data
- mem_rvalid  input  1  read data valid
- write_EN  output  1  register file write enable
- reg_write_add  output  3  register file write address
- reg_write_data  output  16  register file write data
- pending_valid  output  1  a register write is outstanding (MEM_WAIT or WRITE)
- pending_add  output  3  destination of the outstanding write
- mem_err  output  1  sticky load-timeout flag

## Operation
- States: IDLE, MEM_WAIT, WRITE. All outputs are registered or decoded from state registers only.
- `in_ready` = 1 in IDLE and WRITE, 0 in MEM_WAIT.
- Accept = `in_valid & in_ready` at a rising edge. Effective write = `in_reg_write & (in_dest != 0)`; writes to r0 are suppressed here.
- On accept:
  - load with effective write: latch dest/byte flag, `mem_addr <= in_alu_result`, `mem_req` high for the next cycle only, clear the timeout counter, go to MEM_WAIT.
  - non-load with effective write: latch dest/data, go to WRITE.
  - otherwise (no write, or dest 0, including loads): no-op, no memory request, go to IDLE.
- No accept in WRITE -> IDLE. No accept in IDLE -> stay.
- MEM_WAIT:
  - `mem_rvalid` = 1 -> capture formatted data, go to WRITE.
  - else increment the counter; if it reaches MEM_TIMEOUT, go to IDLE, set `mem_err`, and drop the write.
  - `mem_rvalid` is ignored in IDLE and WRITE.
- Load formatting:
  - word: data = `mem_rdata`.
  - byte: `mem_addr[0]`=0 selects `[7:0]`, 1 selects `[15:8]`; sign-extend bit 7 of the selected byte to 16 bits.
- WRITE: `write_EN`=1 with the latched address/data for exactly one cycle per retiring write.
- `pending_valid`=1 in MEM_WAIT and WRITE; `pending_add` = latched dest. An accept in WRITE updates pending to the new instruction from the next cycle.
- `mem_err` stays set until `rst`.

## Timing
- Reset (async, any state): state IDLE, `in_ready`=1, `mem_req`=0, `mem_addr`=0, `write_EN`=0, `reg_write_add`=0, `reg_write_data`=0, `pending_valid`=0, `pending_add`=0, `mem_err`=0, counter 0. A response arriving after reset mid-load is ignored.
- ALU op accepted at edge k: `write_EN` high in cycle k..k+1; the register file captures at edge k+1. Back-to-back accepts give one write per cycle.
- Load accepted at edge k: `mem_req` high in cycle k..k+1. `mem_rvalid` sampled at edge j (k+1 <= j <= k+MEM_TIMEOUT) -> `write_EN` in cycle j..j+1.
- Timeout: no `mem_rvalid` through edge k+MEM_TIMEOUT -> IDLE after that edge. If `mem_rvalid` arrives at exactly edge k+MEM_TIMEOUT, the data wins and no error is flagged.
- Minimum load occupancy: 2 cycles (MEM_WAIT, WRITE); `in_ready` is low for at least 1 cycle.

## Test plan
- Reset, then ALU op dest=3, result 0x1234 at edge k -> `write_EN`=1, add=3, data=0x1234 in cycle k..k+1 only; `in_ready` stays 1.
- Three back-to-back ALU ops (dest 1/2/3, data 0xAAAA/0x5555/0x00FF) -> three consecutive single-cycle writes in order; an op with dest=0 or `in_reg_write`=0 produces no write.
- Word load to address 0x0040, `mem_rvalid` after 3 cycles with 0xBEEF -> `mem_req` pulses once, `mem_addr`=0x0040 held, `in_ready`=0 while waiting, `pending_add` = dest, then write 0xBEEF.
- Byte loads: address 0x0041 with rdata 0x80FF -> 0xFF80; address 0x0040 with rdata 0x80FF -> 0xFFFF; address 0x0040 with rdata 0x127F -> 0x007F.
- MEM_TIMEOUT=4, no response -> IDLE after 4 edges, `mem_err`=1 sticky, no write, a later stray `mem_rvalid` is ignored. Response at exactly edge 4 -> write occurs and `mem_err` stays 0.
- Assert `rst` mid MEM_WAIT, then deliver `mem_rvalid` -> all outputs reset, no write, `in_ready`=1.
